led_display_hub75_driver: RTL and testbench

- Downstream stage of the row pattern generator.
- Accepts one rgb_row_t (top and bottom half-rows) plus a 4-bit row address over a valid/ready handshake.
- Serialises the row onto the HUB75 panel interface: six colour data lines, shift clock, latch, output enable and address.
- Displays the row for a fixed on-time, then requests the next row. Exactly one row is in flight; there is no overlap between shifting and display.

---
 rtl/led_display_hub75_driver.sv | 247 ++++++++++++++++++++++++
 tb/tb_led_display_hub75_driver.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_display_hub75_driver.sv
// HUB75 panel driver: shifts one captured top/bottom row pair out MSB first,
// then blanks, latches and shows it for a fixed on-time before asking for the next row.
module led_display_hub75_driver #(
    parameter int SYS_CLK_FREQ  = 100_000_000,
    parameter int SHIFT_CLK_DIV = 2,
    parameter int BLANK_CYCLES  = 4,
    parameter int LATCH_CYCLES  = 2,
    parameter int ON_CYCLES     = 100,
    localparam int GL_NUM_COL_PIXELS = 64,
    localparam int GL_RGB_ROW_W      = 6 * GL_NUM_COL_PIXELS
) (
    input  logic                    clk_in,
    input  logic                    reset_in,
    input  logic [GL_RGB_ROW_W-1:0] row_in,
    input  logic                    row_valid_in,
    output logic                    row_ready_out,
    input  logic [3:0]              row_address_in,
    output logic                    hub75_r0_out,
    output logic                    hub75_g0_out,
    output logic                    hub75_b0_out,
    output logic                    hub75_r1_out,
    output logic                    hub75_g1_out,
    output logic                    hub75_b1_out,
    output logic                    hub75_clk_out,
    output logic                    hub75_lat_out,
    output logic                    hub75_oe_n_out,
    output logic [3:0]              hub75_addr_out
);

    typedef struct packed {
        logic [GL_NUM_COL_PIXELS-1:0] red;
        logic [GL_NUM_COL_PIXELS-1:0] green;
        logic [GL_NUM_COL_PIXELS-1:0] blue;
    } rgb_half_t;

    typedef struct packed {
        rgb_half_t top;
        rgb_half_t bot;
    } rgb_row_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SHIFT   = 3'd1,
        ST_BLANK   = 3'd2,
        ST_LATCH   = 3'd3,
        ST_DISPLAY = 3'd4
    } state_t;

    localparam int COL_W   = $clog2(GL_NUM_COL_PIXELS);
    localparam int PH_W    = $clog2(SHIFT_CLK_DIV) + 1;
    localparam int DUR_MAX = (ON_CYCLES > BLANK_CYCLES)
                           ? ((ON_CYCLES > LATCH_CYCLES) ? ON_CYCLES : LATCH_CYCLES)
                           : ((BLANK_CYCLES > LATCH_CYCLES) ? BLANK_CYCLES : LATCH_CYCLES);
    localparam int DUR_W   = $clog2(DUR_MAX) + 1;

    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(GL_NUM_COL_PIXELS - 1);
    localparam logic [COL_W-1:0] COL_ZERO   = {COL_W{1'b0}};
    localparam logic [COL_W-1:0] COL_ONE    = COL_W'(1);
    localparam logic [PH_W-1:0]  PH_LAST    = PH_W'(SHIFT_CLK_DIV - 1);
    localparam logic [PH_W-1:0]  PH_ZERO    = {PH_W{1'b0}};
    localparam logic [PH_W-1:0]  PH_ONE     = PH_W'(1);
    localparam logic [DUR_W-1:0] DUR_ZERO   = {DUR_W{1'b0}};
    localparam logic [DUR_W-1:0] DUR_ONE    = DUR_W'(1);
    localparam logic [DUR_W-1:0] BLANK_LOAD = DUR_W'(BLANK_CYCLES - 1);
    localparam logic [DUR_W-1:0] LATCH_LOAD = DUR_W'(LATCH_CYCLES - 1);
    localparam logic [DUR_W-1:0] ON_LOAD    = DUR_W'(ON_CYCLES - 1);

    if ((SYS_CLK_FREQ < 1) || (SHIFT_CLK_DIV < 1) || (BLANK_CYCLES < 1) ||
        (LATCH_CYCLES < 1) || (ON_CYCLES < 1)) begin : g_param_check
        $error("led_display_hub75_driver: frequency and cycle parameters must be >= 1");
    end

    state_t          state_r;
    state_t          state_next_s;
    logic [COL_W-1:0] col_r;
    logic [COL_W-1:0] col_next_s;
    logic [PH_W-1:0]  ph_r;
    logic [PH_W-1:0]  ph_next_s;
    logic             half_r;
    logic             half_next_s;
    logic [DUR_W-1:0] dur_r;
    logic [DUR_W-1:0] dur_next_s;

    rgb_row_t   row_in_s;
    rgb_row_t   row_r;
    rgb_row_t   row_sel_s;
    logic [3:0] addr_cap_r;
    logic       take_s;

    logic [5:0] data_next_s;
    logic       clk_next_s;
    logic       lat_next_s;
    logic       oe_n_next_s;
    logic       ready_next_s;
    logic [3:0] addr_next_s;

    assign row_in_s = row_in;
    assign take_s   = (state_r == ST_IDLE) && row_valid_in && row_ready_out;

    // State and sequencing counters
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_r <= ST_IDLE;
            col_r   <= COL_ZERO;
            ph_r    <= PH_ZERO;
            half_r  <= 1'b0;
            dur_r   <= DUR_ZERO;
        end else begin
            state_r <= state_next_s;
            col_r   <= col_next_s;
            ph_r    <= ph_next_s;
            half_r  <= half_next_s;
            dur_r   <= dur_next_s;
        end
    end

    // Next state; every counter is reloaded on entry so none wraps inside a state
    always_comb begin
        state_next_s = state_r;
        col_next_s   = col_r;
        ph_next_s    = ph_r;
        half_next_s  = half_r;
        dur_next_s   = dur_r;
        case (state_r)
            ST_IDLE: begin
                if (take_s) begin
                    state_next_s = ST_SHIFT;
                    col_next_s   = COL_LAST;
                    ph_next_s    = PH_ZERO;
                    half_next_s  = 1'b0;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (ph_r == PH_LAST) begin
                    ph_next_s = PH_ZERO;
                    if (!half_r) begin
                        half_next_s = 1'b1;
                    end else if (col_r == COL_ZERO) begin
                        half_next_s  = 1'b0;
                        state_next_s = ST_BLANK;
                        dur_next_s   = BLANK_LOAD;
                    end else begin
                        half_next_s = 1'b0;
                        col_next_s  = col_r - COL_ONE;
                    end
                end else begin
                    ph_next_s = ph_r + PH_ONE;
                end
            end
            ST_BLANK: begin
                if (dur_r == DUR_ZERO) begin
                    state_next_s = ST_LATCH;
                    dur_next_s   = LATCH_LOAD;
                end else begin
                    dur_next_s = dur_r - DUR_ONE;
                end
            end
            ST_LATCH: begin
                if (dur_r == DUR_ZERO) begin
                    state_next_s = ST_DISPLAY;
                    dur_next_s   = ON_LOAD;
                end else begin
                    dur_next_s = dur_r - DUR_ONE;
                end
            end
            ST_DISPLAY: begin
                if (dur_r == DUR_ZERO) begin
                    state_next_s = ST_IDLE;
                end else begin
                    dur_next_s = dur_r - DUR_ONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Panel outputs derived from the upcoming state so the registered pins line up with it
    always_comb begin
        if (state_r == ST_IDLE) begin
            row_sel_s = row_in_s;
        end else begin
            row_sel_s = row_r;
        end
        if (state_next_s == ST_SHIFT) begin
            data_next_s = {row_sel_s.top.red[col_next_s], row_sel_s.top.green[col_next_s],
                           row_sel_s.top.blue[col_next_s], row_sel_s.bot.red[col_next_s],
                           row_sel_s.bot.green[col_next_s], row_sel_s.bot.blue[col_next_s]};
            clk_next_s  = half_next_s;
        end else begin
            data_next_s = 6'b000000;
            clk_next_s  = 1'b0;
        end
        lat_next_s   = (state_next_s == ST_LATCH);
        oe_n_next_s  = (state_next_s != ST_DISPLAY);
        ready_next_s = (state_next_s == ST_IDLE);
        if ((state_r == ST_SHIFT) && (state_next_s == ST_BLANK)) begin
            addr_next_s = addr_cap_r;
        end else begin
            addr_next_s = hub75_addr_out;
        end
    end

    // Row and address capture at the handshake
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            row_r      <= {GL_RGB_ROW_W{1'b0}};
            addr_cap_r <= 4'd0;
        end else if (take_s) begin
            row_r      <= row_in_s;
            addr_cap_r <= row_address_in;
        end
    end

    // Registered panel and handshake outputs
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            row_ready_out  <= 1'b0;
            hub75_r0_out   <= 1'b0;
            hub75_g0_out   <= 1'b0;
            hub75_b0_out   <= 1'b0;
            hub75_r1_out   <= 1'b0;
            hub75_g1_out   <= 1'b0;
            hub75_b1_out   <= 1'b0;
            hub75_clk_out  <= 1'b0;
            hub75_lat_out  <= 1'b0;
            hub75_oe_n_out <= 1'b1;
            hub75_addr_out <= 4'd0;
        end else begin
            row_ready_out  <= ready_next_s;
            hub75_r0_out   <= data_next_s[5];
            hub75_g0_out   <= data_next_s[4];
            hub75_b0_out   <= data_next_s[3];
            hub75_r1_out   <= data_next_s[2];
            hub75_g1_out   <= data_next_s[1];
            hub75_b1_out   <= data_next_s[0];
            hub75_clk_out  <= clk_next_s;
            hub75_lat_out  <= lat_next_s;
            hub75_oe_n_out <= oe_n_next_s;
            hub75_addr_out <= addr_next_s;
        end
    end

endmodule

// File: tb/tb_led_display_hub75_driver.sv
// Directed bench for led_display_hub75_driver: reset, single row, back-to-back rows,
// busy-time valid, and mid-operation resets, with a panel-side edge monitor.
module tb_led_display_hub75_driver;

    logic         clk_in = 1'b0;
    logic         reset_in = 1'b0;
    logic [383:0] row_in;
    logic         row_valid_in;
    logic         row_ready_out;
    logic [3:0]   row_address_in;
    logic         hub75_r0_out, hub75_g0_out, hub75_b0_out;
    logic         hub75_r1_out, hub75_g1_out, hub75_b1_out;
    logic         hub75_clk_out, hub75_lat_out, hub75_oe_n_out;
    logic [3:0]   hub75_addr_out;

    led_display_hub75_driver dut (
        .clk_in         (clk_in),
        .reset_in       (reset_in),
        .row_in         (row_in),
        .row_valid_in   (row_valid_in),
        .row_ready_out  (row_ready_out),
        .row_address_in (row_address_in),
        .hub75_r0_out   (hub75_r0_out),
        .hub75_g0_out   (hub75_g0_out),
        .hub75_b0_out   (hub75_b0_out),
        .hub75_r1_out   (hub75_r1_out),
        .hub75_g1_out   (hub75_g1_out),
        .hub75_b1_out   (hub75_b1_out),
        .hub75_clk_out  (hub75_clk_out),
        .hub75_lat_out  (hub75_lat_out),
        .hub75_oe_n_out (hub75_oe_n_out),
        .hub75_addr_out (hub75_addr_out)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs_cnt = 0;

    always @(posedge clk_in) begin
        cyc <= cyc + 1;
        if (row_valid_in && row_ready_out) hs_cnt <= hs_cnt + 1;
    end

    // Panel-side monitor: records data at each shift-clock rise and counts rule breaks
    logic [5:0]  data_s;
    logic        prev_clk = 1'b0;
    logic [5:0]  prev_data = 6'b0;
    int          edges = 0, lat_cyc = 0, oe_cyc = 0;
    int          excl_viol = 0, clk_viol = 0, stab_viol = 0;
    logic [63:0] seen_r0 = 64'd0, seen_g0 = 64'd0, seen_b0 = 64'd0;
    logic [63:0] seen_r1 = 64'd0, seen_g1 = 64'd0, seen_b1 = 64'd0;

    assign data_s = {hub75_r0_out, hub75_g0_out, hub75_b0_out,
                     hub75_r1_out, hub75_g1_out, hub75_b1_out};

    always @(negedge clk_in) begin
        prev_clk  <= hub75_clk_out;
        prev_data <= data_s;
        if (!prev_clk && hub75_clk_out) begin
            edges <= edges + 1;
            if (data_s !== prev_data) stab_viol <= stab_viol + 1;
            seen_r0 <= {seen_r0[62:0], hub75_r0_out};
            seen_g0 <= {seen_g0[62:0], hub75_g0_out};
            seen_b0 <= {seen_b0[62:0], hub75_b0_out};
            seen_r1 <= {seen_r1[62:0], hub75_r1_out};
            seen_g1 <= {seen_g1[62:0], hub75_g1_out};
            seen_b1 <= {seen_b1[62:0], hub75_b1_out};
        end
        if (hub75_lat_out && !hub75_oe_n_out) excl_viol <= excl_viol + 1;
        if (hub75_clk_out && (hub75_lat_out || !hub75_oe_n_out)) clk_viol <= clk_viol + 1;
        if (hub75_lat_out) lat_cyc <= lat_cyc + 1;
        if (!hub75_oe_n_out) oe_cyc <= oe_cyc + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [383:0] make_row(input logic [63:0] t_r, input logic [63:0] t_g,
                                               input logic [63:0] t_b, input logic [63:0] b_r,
                                               input logic [63:0] b_g, input logic [63:0] b_b);
        return {t_r, t_g, t_b, b_r, b_g, b_b};
    endfunction

    task automatic wait_ready(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (row_ready_out === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_in);
        end
    endtask

    task automatic wait_oe_low(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (hub75_oe_n_out === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_in);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, row_ready_out, 1'b0);
        check({tag, "_data"}, data_s, 6'b0);
        check({tag, "_clk"}, hub75_clk_out, 1'b0);
        check({tag, "_lat"}, hub75_lat_out, 1'b0);
        check({tag, "_oe_n"}, hub75_oe_n_out, 1'b1);
        check({tag, "_addr"}, hub75_addr_out, 4'd0);
    endtask

    int   t0, t_prev, e0, l0, o0, h0;
    logic ok;
    logic [3:0] exp_addr;

    initial begin
        row_valid_in   = 1'b0;
        row_in         = 384'd0;
        row_address_in = 4'd0;
        #2 reset_in = 1'b1;
        repeat (3) @(negedge clk_in);
        check_reset_outputs("in_reset");
        reset_in = 1'b0;
        check("ready_before_first_edge", row_ready_out, 1'b0);
        @(negedge clk_in);
        check("ready_after_release", row_ready_out, 1'b1);
        check("oe_n_after_release", hub75_oe_n_out, 1'b1);
        check("lat_after_release", hub75_lat_out, 1'b0);
        check("clk_after_release", hub75_clk_out, 1'b0);
        check("addr_after_release", hub75_addr_out, 4'd0);

        // Single row, valid pulsed once
        row_in = make_row(64'h8000_0000_0000_0001, 64'd0, 64'd0, 64'd0, 64'd0, {64{1'b1}});
        row_address_in = 4'd5;
        row_valid_in = 1'b1;
        e0 = edges; l0 = lat_cyc; o0 = oe_cyc;
        @(posedge clk_in); #1;
        row_valid_in = 1'b0;
        row_in = 384'd0;
        t0 = cyc;
        check("single_ready_dropped", row_ready_out, 1'b0);
        wait_ready(ok);
        check("single_ready_timeout", ok, 1'b1);
        check("single_latency", 64'(cyc - t0), 64'd362);
        check("single_edges", 64'(edges - e0), 64'd64);
        check("single_r0", seen_r0, 64'h8000_0000_0000_0001);
        check("single_b1", seen_b1, {64{1'b1}});
        check("single_g0", seen_g0, 64'd0);
        check("single_b0", seen_b0, 64'd0);
        check("single_r1", seen_r1, 64'd0);
        check("single_g1", seen_g1, 64'd0);
        check("single_addr", hub75_addr_out, 4'd5);
        check("single_lat_cycles", 64'(lat_cyc - l0), 64'd2);
        check("single_oe_cycles", 64'(oe_cyc - o0), 64'd100);

        // Valid held high, address 0..15..0..1
        row_in = make_row(64'd0, 64'h0F0F_0F0F_0F0F_0F0F, 64'd0, 64'd0, 64'd0, 64'd0);
        row_address_in = 4'd0;
        row_valid_in = 1'b1;
        t_prev = cyc;
        for (int k = 1; k < 18; k++) begin
            @(posedge clk_in); #1;
            row_address_in = 4'(k % 16);
            wait_ready(ok);
            check("stream_ready_timeout", ok, 1'b1);
            check("stream_spacing", 64'(cyc - t_prev), 64'd363);
            exp_addr = 4'((k - 1) % 16);
            check("stream_addr", hub75_addr_out, exp_addr);
            t_prev = cyc;
        end
        row_valid_in = 1'b0;

        // Valid held while busy with row_in changing
        row_in = make_row(64'd0, 64'hA5A5_0F0F_1234_8001, 64'd0, 64'h0123_4567_89AB_CDEF, 64'd0, 64'd0);
        row_address_in = 4'd7;
        row_valid_in = 1'b1;
        h0 = hs_cnt;
        @(posedge clk_in); #1;
        for (int i = 0; i < 300; i++) begin
            for (int j = 0; j < 12; j++) row_in[j*32 +: 32] = $urandom;
            @(negedge clk_in);
        end
        row_valid_in = 1'b0;
        wait_ready(ok);
        check("busy_ready_timeout", ok, 1'b1);
        check("busy_handshakes", 64'(hs_cnt - h0), 64'd1);
        check("busy_g0", seen_g0, 64'hA5A5_0F0F_1234_8001);
        check("busy_r1", seen_r1, 64'h0123_4567_89AB_CDEF);
        check("busy_r0", seen_r0, 64'd0);
        check("busy_b1", seen_b1, 64'd0);
        check("busy_addr", hub75_addr_out, 4'd7);

        // Reset during SHIFT at column 30
        row_in = make_row(64'd0, 64'd0, 64'd0, 64'd0, 64'hFFFF_0000_FFFF_0000, 64'd0);
        row_address_in = 4'd2;
        row_valid_in = 1'b1;
        e0 = edges;
        @(posedge clk_in); #1;
        row_valid_in = 1'b0;
        repeat (133) @(posedge clk_in);
        #1;
        check("midshift_edges_before_reset", 64'(edges - e0), 64'd33);
        reset_in = 1'b1;
        #1;
        check_reset_outputs("midshift_reset");
        @(negedge clk_in);
        reset_in = 1'b0;
        wait_ready(ok);
        check("midshift_ready_timeout", ok, 1'b1);
        row_in = make_row(64'd0, 64'd0, 64'hF000_0000_0000_000F, 64'd0, 64'd0, 64'd0);
        row_address_in = 4'd9;
        row_valid_in = 1'b1;
        e0 = edges;
        @(posedge clk_in); #1;
        row_valid_in = 1'b0;
        wait_ready(ok);
        check("after_shift_reset_timeout", ok, 1'b1);
        check("after_shift_reset_edges", 64'(edges - e0), 64'd64);
        check("after_shift_reset_b0", seen_b0, 64'hF000_0000_0000_000F);
        check("after_shift_reset_g1", seen_g1, 64'd0);
        check("after_shift_reset_addr", hub75_addr_out, 4'd9);

        // Reset during DISPLAY
        row_in = make_row(64'h0123_4567_89AB_CDEF, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0);
        row_address_in = 4'd12;
        row_valid_in = 1'b1;
        @(posedge clk_in); #1;
        row_valid_in = 1'b0;
        wait_oe_low(ok);
        check("middisp_oe_timeout", ok, 1'b1);
        repeat (10) @(negedge clk_in);
        reset_in = 1'b1;
        #1;
        check_reset_outputs("middisp_reset");
        @(negedge clk_in);
        reset_in = 1'b0;
        wait_ready(ok);
        check("middisp_ready_timeout", ok, 1'b1);
        row_in = make_row(64'd0, 64'd0, 64'd0, 64'hDEAD_BEEF_0000_FFFF, 64'd0, 64'd0);
        row_address_in = 4'd3;
        row_valid_in = 1'b1;
        e0 = edges; o0 = oe_cyc;
        @(posedge clk_in); #1;
        row_valid_in = 1'b0;
        wait_ready(ok);
        check("after_disp_reset_timeout", ok, 1'b1);
        check("after_disp_reset_edges", 64'(edges - e0), 64'd64);
        check("after_disp_reset_r1", seen_r1, 64'hDEAD_BEEF_0000_FFFF);
        check("after_disp_reset_r0", seen_r0, 64'd0);
        check("after_disp_reset_addr", hub75_addr_out, 4'd3);
        check("after_disp_reset_oe_cycles", 64'(oe_cyc - o0), 64'd100);

        check("lat_oe_exclusive", 64'(excl_viol), 64'd0);
        check("clk_only_in_shift", 64'(clk_viol), 64'd0);
        check("data_stable_at_rise", 64'(stab_viol), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
